// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle for the multicycle MIPS controller.
// The master modport is the controller: it consumes the IR fields and the
// ALU zero flag and drives every datapath mux select and write enable.
// The slave modport is the datapath side of the same signals.
interface multicycle_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, instr_done, illegal_op
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: Moore FSM sequencing a shared-memory datapath.
// Op (latched in IR) picks the state path after DECODE; a small ALU decoder
// turns the per-state ALUOp plus Funct into ALUControl.
// Build option: define MCFSM_ADDI_EN to add the addi path (ADDIEX/ADDIWB);
// without it Op 001000 is rejected in DECODE like any other unknown opcode.
// Handshake: there is no valid/ready; the controller advances one state per
// clock unconditionally and the datapath must honour every enable in the
// cycle it is asserted.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus,
  output logic [STATE_W-1:0]        state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_RTYPEEX = STATE_W'(6),
    S_ALUWB   = STATE_W'(7),
    S_BEQEX   = STATE_W'(8),
`ifdef MCFSM_ADDI_EN
    S_ADDIEX  = STATE_W'(9),
    S_ADDIWB  = STATE_W'(10),
`endif
    S_JEX     = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCFSM_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t     state_q;
  state_t     state_d;
  logic       op_legal;

  logic       pc_write;
  logic       branch;
  logic [1:0] alu_op;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       memto_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       done;
  logic       illegal;
  logic [2:0] alu_control;

  // Opcodes that DECODE knows how to dispatch.
  always_comb begin
    op_legal = 1'b0;
    case (bus.Op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MCFSM_ADDI_EN
      OP_ADDI: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // State register; reset jumps straight to FETCH without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; any code outside the defined set recovers to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
`ifdef MCFSM_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_ALUWB;
`ifdef MCFSM_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; everything not named for a state stays 0.
  always_comb begin
    pc_write  = 1'b0;
    branch    = 1'b0;
    alu_op    = 2'b00;
    iord      = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src    = 2'b00;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        // An unknown opcode ends the instruction here, so it also completes.
        illegal   = ~op_legal;
        done      = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        done      = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
        done      = 1'b1;
      end
`ifdef MCFSM_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
`endif
      S_JEX: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: fixed add/sub for address and branch work, Funct for R-type.
  always_comb begin
    alu_control = 3'b010;
    case (alu_op)
      2'b00: alu_control = 3'b010;
      2'b01: alu_control = 3'b110;
      2'b10: begin
        case (bus.Funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b010;
        endcase
      end
      default: alu_control = 3'b010;
    endcase
  end

  // While reset is held the state already reads FETCH; the write enables
  // are forced low so nothing in the datapath changes during reset.
  assign bus.IorD       = iord;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write & ~reset;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = memto_reg;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.PCSrc      = pc_src;
  assign bus.PCEn       = (pc_write | (branch & bus.Zero)) & ~reset;
  assign bus.instr_done = done & ~reset;
  assign bus.illegal_op = illegal & ~reset;
  assign state          = state_q;

endmodule
